// File: rtl/relay_flow_ctrl.sv
// Valid-gated relay of CYCLE stages that shifts only on an accept or a drain step.
// A flush pushes bubbles in until every resident word has been delivered downstream.
module relay_flow_ctrl #(
    parameter int CYCLE = 4,
    parameter int WIDTH = 11,
    parameter int CW    = $clog2(CYCLE + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    occupancy,
    output logic             draining,
    output logic             flush_done
);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t                        state_q, state_d;
    logic [CYCLE-1:0][WIDTH-1:0]   data_q;
    logic [CYCLE-1:0]              vbit_q;
    logic [CW-1:0]                 occ_q, occ_d;
    logic                          done_q, done_d;

    logic last_free, acc, adv, xfer;

    assign last_free = out_ready | ~vbit_q[CYCLE-1];
    assign in_ready  = last_free & (state_q == RUN);
    assign acc       = in_valid & in_ready;
    assign adv       = acc | ((state_q == DRAIN) & last_free);
    // In RUN the last word only leaves when a new one pushes it out, so validity follows in_valid.
    assign out_valid = vbit_q[CYCLE-1] & (((state_q == RUN) & in_valid) | (state_q == DRAIN));
    assign xfer      = out_valid & out_ready;

    assign out_data   = data_q[CYCLE-1];
    assign occupancy  = occ_q;
    assign draining   = (state_q == DRAIN);
    assign flush_done = done_q;

    always_comb begin
        occ_d   = occ_q + CW'(acc) - CW'(xfer);
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            RUN: begin
                if (flush) begin
                    if (occ_d != '0) state_d = DRAIN;
                    else             done_d  = 1'b1;
                end
            end
            DRAIN: begin
                if (occ_d == '0) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            occ_q   <= '0;
            done_q  <= 1'b0;
            data_q  <= '0;
            vbit_q  <= '0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            done_q  <= done_d;
            if (adv) begin
                // Stage 0 takes a bubble during DRAIN since acc is low there.
                data_q[0] <= in_data;
                vbit_q[0] <= acc;
                for (int i = 1; i < CYCLE; i++) begin
                    data_q[i] <= data_q[i-1];
                    vbit_q[i] <= vbit_q[i-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_relay_flow_ctrl.sv
// Bench for relay_flow_ctrl: directed vector table, reset-in-drain sequence and
// random traffic against a queue-plus-gap model of the relay.
module tb_relay_flow_ctrl;
    localparam int CYCLE = 4;
    localparam int WIDTH = 11;
    localparam int CW    = $clog2(CYCLE + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    occupancy;
    logic             draining;
    logic             flush_done;

    relay_flow_ctrl #(.CYCLE(CYCLE), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .occupancy(occupancy), .draining(draining), .flush_done(flush_done)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    // Model: words resident in arrival order, plus the number of bubble shifts still
    // needed before the oldest word sits in the last stage.
    logic [WIDTH-1:0] mq[$];
    int               gap;
    bit               m_run;
    bit               m_done;

    typedef struct {
        bit               iv;
        logic [WIDTH-1:0] d;
        bit               fl;
        bit               ordy;
        bit               e_ir;
        bit               e_ov;
        logic [WIDTH-1:0] e_od;
        int               e_occ;
        bit               e_drn;
        bit               e_done;
    } vec_t;

    vec_t tbl[31];

    function automatic vec_t v(bit iv, int d, bit fl, bit ordy, bit ir, bit ov, int od,
                               int occ, bit drn, bit dn);
        vec_t r;
        r.iv = iv; r.d = WIDTH'(d); r.fl = fl; r.ordy = ordy;
        r.e_ir = ir; r.e_ov = ov; r.e_od = WIDTH'(od); r.e_occ = occ;
        r.e_drn = drn; r.e_done = dn;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        gap    = CYCLE;
        m_run  = 1'b1;
        m_done = 1'b0;
    endtask

    task automatic drive(input bit iv, input logic [WIDTH-1:0] d, input bit fl, input bit ordy);
        in_valid  = iv;
        in_data   = d;
        flush     = fl;
        out_ready = ordy;
    endtask

    // Compares the DUT against the model for the inputs now applied, then advances the model.
    task automatic mcheck(input bit iv, input logic [WIDTH-1:0] d, input bit fl, input bit ordy);
        bit lv, lf, eir, eov, acc, xfer, nd;
        lv  = (mq.size() > 0) && (gap == 0);
        lf  = ordy | !lv;
        eir = lf & m_run;
        eov = lv & (m_run ? iv : 1'b1);
        chk("in_ready", 32'(in_ready), 32'(eir));
        chk("out_valid", 32'(out_valid), 32'(eov));
        chk("occupancy", 32'(occupancy), 32'(mq.size()));
        chk("draining", 32'(draining), 32'(!m_run));
        chk("flush_done", 32'(flush_done), 32'(m_done));
        if (eov) chk("out_data", 32'(out_data), 32'(mq[0]));
        acc  = iv & eir;
        xfer = eov & ordy;
        nd   = 1'b0;
        if (m_run) begin
            if (xfer) void'(mq.pop_front());
            if (acc) mq.push_back(d);
            gap = CYCLE - mq.size();
            if (fl) begin
                if (mq.size() > 0) m_run = 1'b0;
                else               nd = 1'b1;
            end
        end else if (lf) begin
            if (lv) void'(mq.pop_front());
            else    gap--;
            if (mq.size() == 0) begin
                m_run = 1'b1;
                gap   = CYCLE;
                nd    = 1'b1;
            end
        end
        m_done = nd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit iv, input logic [WIDTH-1:0] d, input bit fl, input bit ordy);
        drive(iv, d, fl, ordy);
        #1;
        mcheck(iv, d, fl, ordy);
        tick();
    endtask

    initial begin
        //        iv d      fl or  ir ov od     occ drn done
        tbl[0]  = v(1, 'h001, 0, 1, 1, 0, 0,     0, 0, 0);
        tbl[1]  = v(1, 'h002, 0, 1, 1, 0, 0,     1, 0, 0);
        tbl[2]  = v(1, 'h003, 0, 1, 1, 0, 0,     2, 0, 0);
        tbl[3]  = v(1, 'h004, 0, 1, 1, 0, 0,     3, 0, 0);
        tbl[4]  = v(1, 'h005, 0, 1, 1, 1, 'h001, 4, 0, 0);
        tbl[5]  = v(0, 'h000, 0, 0, 0, 0, 0,     4, 0, 0);
        tbl[6]  = v(1, 'h006, 0, 0, 0, 1, 'h002, 4, 0, 0);
        tbl[7]  = v(1, 'h006, 0, 0, 0, 1, 'h002, 4, 0, 0);
        tbl[8]  = v(1, 'h006, 0, 1, 1, 1, 'h002, 4, 0, 0);
        tbl[9]  = v(0, 'h000, 1, 1, 1, 0, 0,     4, 0, 0);
        tbl[10] = v(0, 'h000, 0, 1, 0, 1, 'h003, 4, 1, 0);
        tbl[11] = v(0, 'h000, 0, 1, 0, 1, 'h004, 3, 1, 0);
        tbl[12] = v(0, 'h000, 0, 1, 0, 1, 'h005, 2, 1, 0);
        tbl[13] = v(0, 'h000, 0, 1, 0, 1, 'h006, 1, 1, 0);
        tbl[14] = v(0, 'h000, 0, 1, 1, 0, 0,     0, 0, 1);
        tbl[15] = v(0, 'h000, 1, 1, 1, 0, 0,     0, 0, 0);
        tbl[16] = v(0, 'h000, 0, 1, 1, 0, 0,     0, 0, 1);
        tbl[17] = v(1, 'h0B3, 1, 1, 1, 0, 0,     0, 0, 0);
        tbl[18] = v(0, 'h000, 0, 1, 0, 0, 0,     1, 1, 0);
        tbl[19] = v(0, 'h000, 0, 1, 0, 0, 0,     1, 1, 0);
        tbl[20] = v(0, 'h000, 0, 1, 0, 0, 0,     1, 1, 0);
        tbl[21] = v(0, 'h000, 0, 1, 0, 1, 'h0B3, 1, 1, 0);
        tbl[22] = v(0, 'h000, 0, 1, 1, 0, 0,     0, 0, 1);
        tbl[23] = v(1, 'h0A1, 0, 1, 1, 0, 0,     0, 0, 0);
        tbl[24] = v(1, 'h0A2, 0, 1, 1, 0, 0,     1, 0, 0);
        tbl[25] = v(0, 'h000, 1, 1, 1, 0, 0,     2, 0, 0);
        tbl[26] = v(0, 'h000, 0, 1, 0, 0, 0,     2, 1, 0);
        tbl[27] = v(0, 'h000, 0, 1, 0, 0, 0,     2, 1, 0);
        tbl[28] = v(0, 'h000, 0, 1, 0, 1, 'h0A1, 2, 1, 0);
        tbl[29] = v(0, 'h000, 0, 1, 0, 1, 'h0A2, 1, 1, 0);
        tbl[30] = v(0, 'h000, 0, 1, 1, 0, 0,     0, 0, 1);

        rst_n = 1'b0;
        drive(0, '0, 0, 1);
        model_reset();
        #1;
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst occupancy", 32'(occupancy), 0);
        chk("rst out_data", 32'(out_data), 0);
        chk("rst in_ready", 32'(in_ready), 1);
        chk("rst draining", 32'(draining), 0);
        chk("rst flush_done", 32'(flush_done), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        foreach (tbl[i]) begin
            drive(tbl[i].iv, tbl[i].d, tbl[i].fl, tbl[i].ordy);
            #1;
            chk($sformatf("tbl%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            chk($sformatf("tbl%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            if (tbl[i].e_ov) chk($sformatf("tbl%0d out_data", i), 32'(out_data), 32'(tbl[i].e_od));
            chk($sformatf("tbl%0d occupancy", i), 32'(occupancy), 32'(tbl[i].e_occ));
            chk($sformatf("tbl%0d draining", i), 32'(draining), 32'(tbl[i].e_drn));
            chk($sformatf("tbl%0d flush_done", i), 32'(flush_done), 32'(tbl[i].e_done));
            mcheck(tbl[i].iv, tbl[i].d, tbl[i].fl, tbl[i].ordy);
            tick();
        end

        // Steady stream: 20 words through a relay of depth CYCLE; the model checks order.
        for (int i = 1; i <= 20; i++) step(1, WIDTH'(i), 0, 1);
        chk("stream occupancy", 32'(occupancy), CYCLE);
        step(0, '0, 1, 1);
        for (int i = 0; i < CYCLE + 1; i++) step(0, '0, 0, 1);

        // Async reset while draining two words.
        step(1, 'h0C1, 0, 1);
        step(1, 'h0C2, 0, 1);
        step(0, '0, 1, 1);
        step(0, '0, 0, 1);
        chk("pre-reset draining", 32'(draining), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 32'(out_valid), 0);
        chk("midrst occupancy", 32'(occupancy), 0);
        chk("midrst draining", 32'(draining), 0);
        chk("midrst in_ready", 32'(in_ready), 1);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("postrst flush_done", 32'(flush_done), 0);
        for (int i = 0; i < 5; i++) step(1, WIDTH'('h0D1 + i), 0, 1);
        chk("refill occupancy", 32'(occupancy), CYCLE);

        // Random traffic with occasional flushes and backpressure.
        for (int i = 0; i < 600; i++) begin
            bit iv, fl, ordy;
            logic [WIDTH-1:0] d;
            iv   = ($urandom_range(0, 3) != 0);
            d    = WIDTH'($urandom);
            fl   = ($urandom_range(0, 15) == 0);
            ordy = ($urandom_range(0, 9) < 7);
            step(iv, d, fl, ordy);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
